// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX->MEM stage register: default widths, payload layout and width helper.
// The optional second (skid) entry is enabled by defining EX_MEM_SKID_EN.
package ex_mem_pkg;

    localparam int DATA_W_DFLT = 16;
    localparam int REG_W_DFLT  = 4;

    // Field order, most significant first: op1, op2, alu, r15, rd1, rd2, wb, mem.
    typedef struct packed {
        logic [DATA_W_DFLT-1:0] op1;
        logic [DATA_W_DFLT-1:0] op2;
        logic [DATA_W_DFLT-1:0] alu;
        logic [DATA_W_DFLT-1:0] r15;
        logic [REG_W_DFLT-1:0]  rd1;
        logic [REG_W_DFLT-1:0]  rd2;
        logic                   wb;
        logic                   mem;
    } payload_t;

    localparam int PAYLOAD_W = $bits(payload_t);

    function automatic int payloadW(input int dataW, input int regW);
        return 4 * dataW + 2 * regW + 2;
    endfunction

endpackage

// File: rtl/ex_mem_skid_slot.sv
// One pipeline entry: payload register plus valid bit with load/clear controls.
// load has priority over clear so a same-cycle refill keeps the entry valid.
module ex_mem_skid_slot
    import ex_mem_pkg::*;
#(
    parameter int W = PAYLOAD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake, stall, flush and bubble-gated controls.
// Define EX_MEM_SKID_EN to add a second FIFO entry so in_ready becomes a pure register output.
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int REG_W  = REG_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_r15,
    input  logic [REG_W-1:0]  in_rd1,
    input  logic [REG_W-1:0]  in_rd2,
    input  logic              in_wb,
    input  logic              in_mem,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_r15,
    output logic [REG_W-1:0]  out_rd1,
    output logic [REG_W-1:0]  out_rd2,
    output logic              out_wb,
    output logic              out_mem
);

    localparam int PW = payloadW(DATA_W, REG_W);

    // Handshake: a beat moves on a rising edge when valid and ready are both high in
    // that cycle; valid never depends on ready, and flush cancels any same-cycle accept.
    logic          accept;
    logic          drain;
    logic [PW-1:0] inPayload;
    logic [PW-1:0] mIn;
    logic [PW-1:0] mQ;
    logic          mValid;
    logic          mLoad;
    logic          mClear;

    assign inPayload = {in_op1, in_op2, in_alu, in_r15, in_rd1, in_rd2, in_wb, in_mem};
    assign accept    = in_valid & in_ready & ~flush;
    assign drain     = mValid & out_ready;
    assign mClear    = flush | drain;

`ifdef EX_MEM_SKID_EN
    logic [PW-1:0] sQ;
    logic          sValid;
    logic          sLoad;
    logic          sClear;
    logic          mFromS;

    // Ready only reflects skid occupancy, so no path runs from out_ready to in_ready.
    assign in_ready = ~sValid;
    assign mFromS   = drain & sValid & ~flush;
    assign mIn      = mFromS ? sQ : inPayload;
    assign mLoad    = mFromS | (accept & (~mValid | (drain & ~sValid)));
    assign sLoad    = accept & mValid & (~drain | sValid);
    assign sClear   = flush | mFromS;

    ex_mem_skid_slot #(.W(PW)) skidSlot (
        .clk   (clk),
        .rst   (rst),
        .load  (sLoad),
        .clear (sClear),
        .d     (inPayload),
        .q     (sQ),
        .valid (sValid)
    );
`else
    assign in_ready = ~mValid | out_ready;
    assign mIn      = inPayload;
    assign mLoad    = accept;
`endif

    ex_mem_skid_slot #(.W(PW)) mainSlot (
        .clk   (clk),
        .rst   (rst),
        .load  (mLoad),
        .clear (mClear),
        .d     (mIn),
        .q     (mQ),
        .valid (mValid)
    );

    // Data fields hold stale values on a bubble; only the controls are gated.
    assign out_valid = mValid;
    assign out_op1   = mQ[2+2*REG_W+3*DATA_W +: DATA_W];
    assign out_op2   = mQ[2+2*REG_W+2*DATA_W +: DATA_W];
    assign out_alu   = mQ[2+2*REG_W+DATA_W   +: DATA_W];
    assign out_r15   = mQ[2+2*REG_W          +: DATA_W];
    assign out_rd1   = mQ[2+REG_W            +: REG_W];
    assign out_rd2   = mQ[2                  +: REG_W];
    assign out_wb    = mValid & mQ[1];
    assign out_mem   = mValid & mQ[0];

endmodule
